// File: rtl/pj_pkg.sv
// rtl/pj_pkg.sv - shared widths, op encodings and FSM states for the buffer consumer
package pj_pkg;

  localparam int DW    = 4;
  localparam int DEPTH = 7;
  localparam int RW    = 8;

  localparam logic [1:0] OP_SUM  = 2'd0;
  localparam logic [1:0] OP_MAX  = 2'd1;
  localparam logic [1:0] OP_MIN  = 2'd2;
  localparam logic [1:0] OP_EVEN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stat_acc.sv
// rtl/stat_acc.sv - init/accumulate datapath folding words into sum, max, min or even-count
module stat_acc
  import pj_pkg::*;
#(
  parameter int DW = pj_pkg::DW,
  parameter int RW = pj_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          en,
  input  logic [1:0]    op,
  input  logic [DW-1:0] din,
  output logic [RW-1:0] acc
);

  localparam logic [RW-1:0] MIN_INIT = RW'((1 << DW) - 1);

  logic [RW-1:0] din_x;
  logic [RW-1:0] even_inc;

  assign din_x    = RW'(din);
  assign even_inc = {{(RW-1){1'b0}}, ~din[0]};

  // init wins over en so a fresh operation never folds a stale word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (init) begin
      acc <= (op == OP_MIN) ? MIN_INIT : '0;
    end else if (en) begin
      case (op)
        OP_SUM:  acc <= acc + din_x;
        OP_MAX:  if (din_x > acc) acc <= din_x;
        OP_MIN:  if (din_x < acc) acc <= din_x;
        default: acc <= acc + even_inc;
      endcase
    end
  end

endmodule

// File: rtl/stream_alu.sv
// rtl/stream_alu.sv - drains the full buffer with an rd burst and registers one statistic
module stream_alu
  import pj_pkg::*;
#(
  parameter int DW     = pj_pkg::DW,
  parameter int DEPTH  = pj_pkg::DEPTH,
  parameter int RW     = pj_pkg::RW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    math,
  input  logic          full,
  input  logic          empty,
  input  logic [DW-1:0] din,
  output logic          rd,
  output logic          busy,
  output logic          done,
  output logic          short,
  output logic [RW-1:0] result
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  state_t            state;
  logic [1:0]        op_q;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     captured;
  logic [RD_LAT-1:0] vld;
  logic              launch;
  logic              cap;
  logic [1:0]        acc_op;
  logic [RW-1:0]     acc;

  // full together with empty is treated as empty, so it cannot launch
  assign launch = (state == IDLE) && start && full && !empty;
  assign rd     = (state == DRAIN) && !empty && (issued < DEPTH_C);
  assign cap    = vld[RD_LAT-1];
  assign busy   = (state != IDLE);
  assign acc_op = launch ? math : op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_SUM;
      issued   <= '0;
      captured <= '0;
      vld      <= '0;
      done     <= 1'b0;
      short    <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      vld  <= RD_LAT'({vld, rd});
      if (rd)  issued   <= issued + 1'b1;
      if (cap) captured <= captured + 1'b1;

      case (state)
        IDLE: begin
          if (launch) begin
            state    <= DRAIN;
            op_q     <= math;
            issued   <= '0;
            captured <= '0;
          end
        end
        DRAIN: begin
          if (empty || (issued == DEPTH_C) || (rd && (issued == LAST_C)))
            state <= FLUSH;
        end
        FLUSH: begin
          // only finish once every issued read has landed in the accumulator
          if ((captured == issued) && !(|vld)) begin
            state  <= DONE;
            done   <= 1'b1;
            short  <= (captured < DEPTH_C);
            result <= (captured == '0) ? '0 : acc;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  stat_acc #(
    .DW(DW),
    .RW(RW)
  ) u_stat_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .init (launch),
    .en   (cap),
    .op   (acc_op),
    .din  (din),
    .acc  (acc)
  );

endmodule

// File: tb/tb_stream_alu.sv
// tb/tb_stream_alu.sv - scoreboard bench for stream_alu against a 7-entry buffer model
module tb_stream_alu;
  import pj_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       sh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start, full;
  logic [1:0] math;
  logic       empty;
  logic [3:0] din = 4'h0;
  logic       rd, busy, done, short;
  logic [7:0] result;

  logic [3:0] words[7];
  int         rd_idx   = 0;
  int         base     = 0;
  int         limit    = 0;
  logic       hold     = 1'b0;
  int         done_cnt = 0;
  int         total    = 0;
  int         bad      = 0;
  logic [7:0] last_res = 8'h00;
  exp_t       exp_q[$];

  always #5 clk = ~clk;

  assign empty = hold ? 1'b0 : ((rd_idx - base) >= limit);

  always @(posedge clk) begin
    if (rd) begin
      din    <= ((rd_idx - base) < 7) ? words[rd_idx - base] : 4'h0;
      rd_idx <= rd_idx + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  stream_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .math  (math),
    .full  (full),
    .empty (empty),
    .din   (din),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .short (short),
    .result(result)
  );

  function automatic logic [7:0] model(input logic [1:0] op, input int n);
    logic [7:0] a;
    a = (op == OP_MIN) ? 8'd15 : 8'd0;
    for (int i = 0; i < n; i++) begin
      case (op)
        OP_SUM:  a = a + {4'h0, words[i]};
        OP_MAX:  if ({4'h0, words[i]} > a) a = {4'h0, words[i]};
        OP_MIN:  if ({4'h0, words[i]} < a) a = {4'h0, words[i]};
        default: if (words[i][0] == 1'b0) a = a + 8'd1;
      endcase
    end
    return (n == 0) ? 8'd0 : a;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] m, input logic [27:0] w,
                        input int n, input bit chk_lat, input bit disturb);
    exp_t e;
    exp_t got;
    int   r0;
    int   d0;
    int   lat;
    for (int i = 0; i < 7; i++) words[i] = w[4*i +: 4];
    base  = rd_idx;
    limit = n;
    e.res = model(m, n);
    e.sh  = (n < 7);
    exp_q.push_back(e);
    r0 = rd_idx;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; math = m; full = 1'b1; hold = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; full = 1'b0; hold = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (disturb && c == 2) math = ~m;
      if (disturb && c == 3) begin start = 1'b1; full = 1'b1; end
      if (disturb && c == 4) begin start = 1'b0; full = 1'b0; end
      if (done) begin lat = c; break; end
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL %s timeout: done not seen within 40 cycles", tag);
      got = exp_q.pop_front();
      return;
    end
    if (chk_lat) begin
      total++;
      if (lat + 1 !== 10) begin
        bad++;
        $display("FAIL %s latency: got %0d edges, want 10", tag, lat + 1);
      end
    end
    total++;
    if (rd_idx - r0 !== n) begin
      bad++;
      $display("FAIL %s rd_count: got %0d, want %0d", tag, rd_idx - r0, n);
    end
    got = exp_q.pop_front();
    total++;
    if (result !== got.res) begin
      bad++;
      $display("FAIL %s result: got %0d, want %0d", tag, result, got.res);
    end
    total++;
    if (short !== got.sh) begin
      bad++;
      $display("FAIL %s short: got %b, want %b", tag, short, got.sh);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: done=%b busy=%b, want 0 0", tag, done, busy);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL %s done_pulses: got %0d, want 1", tag, done_cnt - d0);
    end
    last_res = got.res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; full = 1'b0; math = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rd, busy, done, short} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: rd/busy/done/short=%b, want 0000", {rd, busy, done, short});
    end
    total++;
    if (result !== 8'h00) begin
      bad++;
      $display("FAIL reset_result: got %0d, want 0", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 8'h00;
  endtask

  task automatic test_ops();
    run_op("sum_1to7",  OP_SUM,  28'h7654321, 7, 1'b1, 1'b0);
    run_op("max_1to7",  OP_MAX,  28'h7654321, 7, 1'b1, 1'b0);
    run_op("min_1to7",  OP_MIN,  28'h7654321, 7, 1'b0, 1'b0);
    run_op("even_1to7", OP_EVEN, 28'h7654321, 7, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op("sum_all15", OP_SUM,  28'hFFFFFFF, 7, 1'b0, 1'b0);
    run_op("min_all0",  OP_MIN,  28'h0000000, 7, 1'b0, 1'b0);
    run_op("even_all0", OP_EVEN, 28'h0000000, 7, 1'b0, 1'b0);
  endtask

  task automatic test_no_full();
    int r0;
    int d0;
    r0 = rd_idx;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; full = 1'b0; math = OP_SUM;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL no_full busy: got %b, want 0", busy);
      end
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rd_idx !== r0 || done_cnt !== d0) begin
      bad++;
      $display("FAIL no_full activity: rd=%0d done=%0d, want 0 0", rd_idx - r0, done_cnt - d0);
    end
    total++;
    if (result !== last_res) begin
      bad++;
      $display("FAIL no_full result: got %0d, want %0d", result, last_res);
    end
  endtask

  task automatic test_busy_ignore();
    run_op("busy_ignore_min", OP_MIN, 28'h7654321, 7, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore requeue: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_early_empty();
    run_op("early4_sum", OP_SUM, 28'h0008642, 4, 1'b0, 1'b0);
    run_op("empty0_sum", OP_SUM, 28'h7654321, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) words[i] = 4'(i + 1);
    base  = rd_idx;
    limit = 7;
    @(negedge clk);
    start = 1'b1; math = OP_SUM; full = 1'b1; hold = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; full = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || rd !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset pre: busy=%b rd=%b, want 1 1", busy, rd);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({rd, busy, done, short} !== 4'b0000 || result !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset state: rd/busy/done/short=%b result=%0d, want 0000 0",
               {rd, busy, done, short}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 8'h00;
    run_op("post_reset_sum", OP_SUM, 28'h7654321, 7, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_boundaries();
    test_no_full();
    test_busy_ignore();
    test_early_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
